// File: rtl/fetch_controller_pkg.sv
// Shared state encodings and PC constants for the instruction fetch controller.
package fetch_pkg;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_REQ    = 2'd0;
  localparam fetch_state_t ST_WAIT   = 2'd1;
  localparam fetch_state_t ST_HOLD   = 2'd2;
  localparam fetch_state_t ST_HALTED = 2'd3;

  localparam int unsigned INSTR_BYTES = 4;
  // Low PC bits that are forced to zero on a redirect.
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_controller_pc_reg.sv
// Program counter register: async reset to RESET_VECTOR, loads d_i when load_i is high.
module pc_reg #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] pc_q;

  // PC storage with load enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VECTOR;
    end else if (load_i) begin
      pc_q <= d_i;
    end else begin
      pc_q <= pc_q;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: one outstanding imem request, redirect/halt handling.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_killed counters.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_killed
`endif
);

  fetch_state_t          state_q, state_d;
  logic                  kill_q, kill_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic                  pc_load_s;
  logic [DATA_WIDTH-1:0] target_s;
  logic [DATA_WIDTH-1:0] pc_inc_s;
  logic                  fetched_s, killed_s;

  assign target_s = redirect_target & ~{{(DATA_WIDTH-2){1'b0}}, PC_ALIGN_MASK};
  assign pc_inc_s = pc_q + DATA_WIDTH'(INSTR_BYTES);

  pc_reg #(
    .DATA_WIDTH   (DATA_WIDTH),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (pc_load_s),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  // Next-state, next-PC and capture logic
  always_comb begin
    state_d   = state_q;
    kill_d    = kill_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    pc_load_s = 1'b0;
    pc_d      = pc_q;
    fetched_s = 1'b0;
    killed_s  = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (imem_req_ready) begin
          state_d = ST_WAIT;
          if (redirect_valid) begin
            kill_d    = 1'b1;
            pc_load_s = 1'b1;
            pc_d      = target_s;
          end else begin
            kill_d = 1'b0;
          end
        end else if (redirect_valid) begin
          pc_load_s = 1'b1;
          pc_d      = target_s;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          // A killed or same-cycle-redirected response is thrown away.
          if (kill_q || redirect_valid) begin
            kill_d   = 1'b0;
            state_d  = ST_REQ;
            killed_s = 1'b1;
            if (redirect_valid) begin
              pc_load_s = 1'b1;
              pc_d      = target_s;
            end else begin
              pc_load_s = 1'b0;
            end
          end else begin
            instr_d   = imem_rsp_data;
            ipc_d     = pc_q;
            pc_load_s = 1'b1;
            pc_d      = pc_inc_s;
            state_d   = ST_HOLD;
          end
        end else if (redirect_valid) begin
          kill_d    = 1'b1;
          pc_load_s = 1'b1;
          pc_d      = target_s;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_load_s = 1'b1;
          pc_d      = target_s;
          state_d   = ST_REQ;
          killed_s  = 1'b1;
        end else if (instr_ready) begin
          fetched_s = 1'b1;
          if (halt) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_REQ;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALTED: begin
        if (redirect_valid) begin
          pc_load_s = 1'b1;
          pc_d      = target_s;
          state_d   = ST_REQ;
        end else begin
          state_d = ST_HALTED;
        end
      end
      default: begin
        state_d = ST_REQ;
        kill_d  = 1'b0;
      end
    endcase
  end

  // FSM and held-instruction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
      kill_q  <= 1'b0;
      instr_q <= {DATA_WIDTH{1'b0}};
      ipc_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_addr      = pc_q;
  assign instr_valid    = (state_q == ST_HOLD);
  assign instr          = instr_q;
  assign instr_pc       = ipc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, killed_q;

  // Wrapping event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= 32'd0;
      killed_q  <= 32'd0;
    end else begin
      fetched_q <= fetched_s ? fetched_q + 32'd1 : fetched_q;
      killed_q  <= killed_s  ? killed_q  + 32'd1 : killed_q;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_killed  = killed_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = fetched_s ^ killed_s;
`endif

endmodule
